// File: rtl/key_capture_pkg.sv
// Shared types and helpers for the key capture front end of the 8-to-3 encoder.
package key_capture_pkg;

    localparam int KEY_W            = 8;
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int PTR_W            = $clog2(KEY_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // First set bit of req, searching upward from ptr and wrapping; ptr if req is empty.
    function automatic logic [PTR_W-1:0] rr_first(input logic [KEY_W-1:0] req,
                                                   input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] idx;
        logic             found;
        rr_first = ptr;
        found    = 1'b0;
        for (int k = 0; k < KEY_W; k++) begin
            idx = ptr + PTR_W'(k);
            if (!found && req[idx]) begin
                found    = 1'b1;
                rr_first = idx;
            end
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key line: two-flop synchroniser, optional debounce counter (KEY_DEBOUNCE_EN)
// and a registered single-cycle pulse on each accepted press.
module key_debounce
    import key_capture_pkg::*;
`ifdef KEY_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 3
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_rise;
    logic w_stable;
    logic w_stable_nxt;

    // Two-flop synchroniser for the asynchronous key level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_accept;

    // The level change is accepted on the edge where the disagreement count reaches DEBOUNCE_CYCLES
    always_comb begin
        w_differ     = r_sync2 ^ r_stable;
        w_accept     = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
        w_stable     = r_stable;
        w_stable_nxt = w_accept ? r_sync2 : r_stable;
    end

    // Debounce counter and accepted stable level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= {CNT_W{1'b0}};
        end else if (w_differ) begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt    <= {CNT_W{1'b0}};
        end
    end
`else
    // Without debounce the second sync flop is the stable level
    always_comb begin
        w_stable     = r_sync2;
        w_stable_nxt = r_sync1;
    end
`endif

    // Pulse aligned with the edge on which stable rises
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
        end else begin
            r_rise <= w_stable_nxt & ~w_stable;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/key_onehot_capture.sv
// Key press capture: per-key sync/debounce, pending latch, round-robin one-hot grant with
// valid/ready. Define KEY_DEBOUNCE_EN to enable the per-key debounce counters.
module key_onehot_capture
    import key_capture_pkg::*;
#(
    parameter int WIDTH = KEY_W
`ifdef KEY_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 3
`endif
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] keys_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] pending,
    output logic             overflow
);

    state_e           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [WIDTH-1:0] r_pending;
    logic             r_overflow;

    logic [WIDTH-1:0] w_rise;
    logic [PTR_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_grant_clr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [WIDTH-1:0] w_lost;

    for (genvar g = 0; g < WIDTH; g++) begin : g_key
        key_debounce
`ifdef KEY_DEBOUNCE_EN
        #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        )
`endif
        u_deb (
            .clk    (clk),
            .rst    (rst),
            .i_key  (keys_in[g]),
            .o_rise (w_rise[g])
        );
    end

    // Arbitration; a press landing on the bit being granted keeps it pending and is not lost
    always_comb begin
        w_grant_idx = rr_first(r_pending, r_ptr);
        if ((r_state == ST_IDLE) && (|r_pending)) begin
            w_grant_clr = {{(WIDTH-1){1'b0}}, 1'b1} << w_grant_idx;
        end else begin
            w_grant_clr = {WIDTH{1'b0}};
        end
        w_ptr_nxt = (w_grant_idx == PTR_W'(WIDTH - 1)) ? {PTR_W{1'b0}} : w_grant_idx + PTR_W'(1);
        w_lost    = w_rise & r_pending & ~w_grant_clr;
    end

    // Pending requests and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= {WIDTH{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_grant_clr) | w_rise;
            r_overflow <= r_overflow | (|w_lost);
        end
    end

    // Grant FSM: IDLE issues one grant, HOLD waits for the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= {PTR_W{1'b0}};
            r_data  <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_data  <= w_grant_clr;
                        r_valid <= 1'b1;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= ST_HOLD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (r_valid && ready) begin
                        r_data  <= {WIDTH{1'b0}};
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_data  <= {WIDTH{1'b0}};
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture; latencies follow KEY_DEBOUNCE_EN (D=4 or 0).
module tb_key_onehot_capture;

`ifdef KEY_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] keys_in;
    logic [7:0] data_out;
    logic [7:0] pending;
    logic       valid;
    logic       overflow;
    logic       inv_en = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    key_onehot_capture dut (
        .clk      (clk),
        .rst      (rst),
        .keys_in  (keys_in),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .overflow (overflow)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output word must always be zero or one-hot, and zero while not valid
    always @(negedge clk) begin
        if (inv_en) begin
            n_tests++;
            if (!$onehot0(data_out) || (!valid && data_out !== 8'h00)) begin
                n_fail++;
                $display("FAIL invariant: data_out=%h valid=%b, required zero or one-hot (zero when valid=0)", data_out, valid);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; keys_in = 8'h00; ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; keys_in = 8'hFF; ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            n_tests++;
            if (valid !== 1'b0 || data_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold: valid=%b data_out=%h, required 0/00", valid, data_out);
            end
        end
        n_tests++;
        if (pending !== 8'h00 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pending=%h overflow=%b, required 00/0", pending, overflow);
        end
        rst = 1'b0; keys_in = 8'h00; inv_en = 1'b1;
        tick(D + 6);
        n_tests++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_quiet: valid=%b pending=%h, required 0/00", valid, pending);
        end
    endtask

    task automatic test_single_press();
        keys_in = 8'h08; ready = 1'b0;
        tick(3 + D);
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: valid=%b, required 0", valid);
        end
        tick(1);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h08 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL single_grant: valid=%b data_out=%h pending=%h, required 1/08/00", valid, data_out, pending);
        end
        tick(3);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h08) begin
            n_fail++;
            $display("FAIL single_hold: valid=%b data_out=%h, required 1/08", valid, data_out);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        n_tests++;
        if (valid !== 1'b0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL single_accept: valid=%b data_out=%h, required 0/00", valid, data_out);
        end
        keys_in = 8'h00;
        tick(D + 4);
    endtask

    task automatic test_glitch();
        logic saw;
        saw = 1'b0;
        keys_in = 8'h20;
        tick(3);
`ifdef KEY_DEBOUNCE_EN
        keys_in = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (valid !== 1'b0 || pending !== 8'h00) saw = 1'b1;
        end
        n_tests++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject: grant/pending seen=%b, required 0", saw);
        end
`else
        n_tests++;
        if (pending !== 8'h20 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_pending: pending=%h valid=%b, required 20/0", pending, valid);
        end
        keys_in = 8'h00;
        tick(1);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h20) begin
            n_fail++;
            $display("FAIL glitch_grant: valid=%b data_out=%h, required 1/20", valid, data_out);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        saw = valid;
        n_tests++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_accept: valid=%b, required 0", saw);
        end
`endif
        tick(4);
    endtask

    task automatic test_back_to_back();
        logic moved;
        moved = 1'b0;
        do_reset();
        keys_in = 8'h42; ready = 1'b0;
        tick(4 + D);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h02 || pending !== 8'h40) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b data_out=%h pending=%h, required 1/02/40", valid, data_out, pending);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (valid !== 1'b1 || data_out !== 8'h02 || pending !== 8'h40) moved = 1'b1;
        end
        n_tests++;
        if (moved !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stall: output changed under backpressure=%b, required 0", moved);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        n_tests++;
        if (valid !== 1'b0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_bubble: valid=%b data_out=%h, required 0/00", valid, data_out);
        end
        tick(1);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h40 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b data_out=%h pending=%h, required 1/40/00", valid, data_out, pending);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        keys_in = 8'h00;
        tick(D + 4);
    endtask

    task automatic test_round_robin();
        keys_in = 8'h81; ready = 1'b0;
        tick(4 + D);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h80 || pending !== 8'h01) begin
            n_fail++;
            $display("FAIL rr_first: valid=%b data_out=%h pending=%h, required 1/80/01", valid, data_out, pending);
        end
        ready = 1'b1;
        tick(1);
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_bubble: valid=%b, required 0", valid);
        end
        tick(1);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h01) begin
            n_fail++;
            $display("FAIL rr_second: valid=%b data_out=%h, required 1/01", valid, data_out);
        end
        tick(1);
        ready = 1'b0;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_accept: valid=%b, required 0", valid);
        end
        keys_in = 8'h00;
        tick(D + 4);
    endtask

    task automatic test_overflow();
        keys_in = 8'h04; ready = 1'b0;
        tick(4 + D);
        n_tests++;
        if (valid !== 1'b1 || data_out !== 8'h04) begin
            n_fail++;
            $display("FAIL ovf_grant: valid=%b data_out=%h, required 1/04", valid, data_out);
        end
        keys_in = 8'h14;
        tick(3 + D);
        n_tests++;
        if (pending !== 8'h10 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_first_press: pending=%h overflow=%b, required 10/0", pending, overflow);
        end
        keys_in = 8'h04;
        tick(D + 4);
        keys_in = 8'h14;
        tick(3 + D);
        n_tests++;
        if (overflow !== 1'b1 || pending !== 8'h10 || valid !== 1'b1 || data_out !== 8'h04) begin
            n_fail++;
            $display("FAIL ovf_set: overflow=%b pending=%h valid=%b data_out=%h, required 1/10/1/04", overflow, pending, valid, data_out);
        end
        rst = 1'b1;
        tick(1);
        n_tests++;
        if (valid !== 1'b0 || data_out !== 8'h00 || pending !== 8'h00 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_mid_reset: valid=%b data_out=%h pending=%h overflow=%b, required 0/00/00/0", valid, data_out, pending, overflow);
        end
        rst = 1'b0; keys_in = 8'h00;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_back_to_back();
        test_round_robin();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
